ysyx_24100029_ibuf: RTL and testbench

Instruction buffer between the 4-wide fetch unit (IFU) and the decode stage. Each cycle it accepts up to four in-order {inst, pc} pairs from the IFU and presents up to four oldest entries to decode. It is a circular queue that decouples fetch bursts from decode stalls, and it is flushed on redirect (`clr`).

---
 rtl/ysyx_24100029_ibuf.sv | 166 ++++++++++++++++
 tb/tb_ysyx_24100029_ibuf.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100029_ibuf.sv
// 4-in/4-out circular instruction buffer between IFU and decode.
// Optional perf counters: define YSYX_24100029_IBUF_PERF_EN.
module ysyx_24100029_ibuf #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int Issue_Num  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clr,
    input  logic [3:0]            in_valid,
    output logic [3:0]            in_ready,
    input  logic [31:0]           in_inst1,
    input  logic [31:0]           in_inst2,
    input  logic [31:0]           in_inst3,
    input  logic [31:0]           in_inst4,
    input  logic [ADDR_WIDTH-1:0] in_pc1,
    input  logic [ADDR_WIDTH-1:0] in_pc2,
    input  logic [ADDR_WIDTH-1:0] in_pc3,
    input  logic [ADDR_WIDTH-1:0] in_pc4,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic [31:0]           out_inst1,
    output logic [31:0]           out_inst2,
    output logic [31:0]           out_inst3,
    output logic [31:0]           out_inst4,
    output logic [ADDR_WIDTH-1:0] out_pc1,
    output logic [ADDR_WIDTH-1:0] out_pc2,
    output logic [ADDR_WIDTH-1:0] out_pc3,
    output logic [ADDR_WIDTH-1:0] out_pc4
`ifdef YSYX_24100029_IBUF_PERF_EN
    ,
    output logic [31:0]           ifu_stall,
    output logic [31:0]           ibuf_full_cyc
`endif
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [31:0]           inst_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] count;
    logic [PW-1:0] free;

    logic [31:0]           in_inst [Issue_Num];
    logic [ADDR_WIDTH-1:0] in_pc   [Issue_Num];
    logic [31:0]           rd_inst [Issue_Num];
    logic [ADDR_WIDTH-1:0] rd_pc   [Issue_Num];

    logic [2:0] n_enq;
    logic [2:0] n_deq;
    logic [3:0] enq_hs;
    logic [3:0] deq_hs;

    assign in_inst[0] = in_inst1;
    assign in_inst[1] = in_inst2;
    assign in_inst[2] = in_inst3;
    assign in_inst[3] = in_inst4;
    assign in_pc[0]   = in_pc1;
    assign in_pc[1]   = in_pc2;
    assign in_pc[2]   = in_pc3;
    assign in_pc[3]   = in_pc4;

    assign count = tail - head;
    assign free  = PW'(DEPTH) - count;

    // Each slot needs room and an unbroken run of valid older slots.
    always_comb begin
        logic pre;
        pre      = 1'b1;
        in_ready = '0;
        for (int i = 0; i < Issue_Num; i++) begin
            in_ready[i] = !reset && (free > PW'(i)) && pre;
            pre         = pre & in_valid[i];
        end
    end

    always_comb begin
        for (int i = 0; i < Issue_Num; i++) begin
            out_valid[i] = count > PW'(i);
        end
    end

    assign enq_hs = in_valid & in_ready;
    assign deq_hs = out_valid & out_ready;

    always_comb begin
        logic stop_e;
        logic stop_d;
        stop_e = 1'b0;
        stop_d = 1'b0;
        n_enq  = '0;
        n_deq  = '0;
        for (int i = 0; i < Issue_Num; i++) begin
            if (!stop_e && enq_hs[i]) n_enq = n_enq + 3'd1;
            else                      stop_e = 1'b1;
            if (!stop_d && deq_hs[i]) n_deq = n_deq + 3'd1;
            else                      stop_d = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < Issue_Num; i++) begin
            rd_inst[i] = inst_q[head[IW-1:0] + IW'(i)];
            rd_pc[i]   = pc_q[head[IW-1:0] + IW'(i)];
        end
    end

    assign out_inst1 = rd_inst[0];
    assign out_inst2 = rd_inst[1];
    assign out_inst3 = rd_inst[2];
    assign out_inst4 = rd_inst[3];
    assign out_pc1   = rd_pc[0];
    assign out_pc2   = rd_pc[1];
    assign out_pc3   = rd_pc[2];
    assign out_pc4   = rd_pc[3];

    always_ff @(posedge clock) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (clr) begin
            head <= '0;
            tail <= '0;
        end else begin
            for (int k = 0; k < Issue_Num; k++) begin
                if (3'(k) < n_enq) begin
                    inst_q[tail[IW-1:0] + IW'(k)] <= in_inst[k];
                    pc_q[tail[IW-1:0] + IW'(k)]   <= in_pc[k];
                end
            end
            head <= head + PW'(n_deq);
            tail <= tail + PW'(n_enq);
        end
    end

`ifdef YSYX_24100029_IBUF_PERF_EN
    logic stall_evt;
    logic full_evt;

    assign stall_evt = in_valid[0] && !in_ready[0];
    assign full_evt  = count == PW'(DEPTH);

    // Counters survive clr so flush-heavy phases stay visible.
    always_ff @(posedge clock) begin
        if (reset) begin
            ifu_stall     <= '0;
            ibuf_full_cyc <= '0;
        end else begin
            if (stall_evt && ifu_stall != 32'hFFFF_FFFF)
                ifu_stall <= ifu_stall + 32'd1;
            if (full_evt && ibuf_full_cyc != 32'hFFFF_FFFF)
                ibuf_full_cyc <= ibuf_full_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_24100029_ibuf.sv
// Directed bench for ysyx_24100029_ibuf: reset, fill, drain/wrap,
// streaming order, gap, flush and optional perf counters.
module tb_ysyx_24100029_ibuf;

    logic        clock = 1'b0;
    logic        reset;
    logic        clr;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_inst1, in_inst2, in_inst3, in_inst4;
    logic [31:0] in_pc1, in_pc2, in_pc3, in_pc4;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_inst1, out_inst2, out_inst3, out_inst4;
    logic [31:0] out_pc1, out_pc2, out_pc3, out_pc4;
`ifdef YSYX_24100029_IBUF_PERF_EN
    logic [31:0] ifu_stall;
    logic [31:0] ibuf_full_cyc;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] opc [4];
    assign opc[0] = out_pc1;
    assign opc[1] = out_pc2;
    assign opc[2] = out_pc3;
    assign opc[3] = out_pc4;

    always #5 clock = ~clock;

    ysyx_24100029_ibuf dut (
        .clock(clock), .reset(reset), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst1(in_inst1), .in_inst2(in_inst2),
        .in_inst3(in_inst3), .in_inst4(in_inst4),
        .in_pc1(in_pc1), .in_pc2(in_pc2),
        .in_pc3(in_pc3), .in_pc4(in_pc4),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst1(out_inst1), .out_inst2(out_inst2),
        .out_inst3(out_inst3), .out_inst4(out_inst4),
        .out_pc1(out_pc1), .out_pc2(out_pc2),
        .out_pc3(out_pc3), .out_pc4(out_pc4)
`ifdef YSYX_24100029_IBUF_PERF_EN
        ,
        .ifu_stall(ifu_stall),
        .ibuf_full_cyc(ibuf_full_cyc)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0000;
    endfunction

    task automatic set_in(input logic [3:0] v, input logic [31:0] pc0);
        in_valid = v;
        in_pc1   = pc0;
        in_pc2   = pc0 + 32'd4;
        in_pc3   = pc0 + 32'd8;
        in_pc4   = pc0 + 32'd12;
        in_inst1 = mk_inst(in_pc1);
        in_inst2 = mk_inst(in_pc2);
        in_inst3 = mk_inst(in_pc3);
        in_inst4 = mk_inst(in_pc4);
    endtask

    initial begin
        int sent, rcvd, mcount, cyc, nv, r, n_acc, n_d;
        logic [3:0] v, exp_rdy, exp_ov;
        logic pre;

        reset     = 1'b1;
        clr       = 1'b0;
        out_ready = 4'b0000;
        set_in(4'b1111, 32'h0);
        #1;
        chk("rst_ready", {28'd0, in_ready}, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_ovalid", {28'd0, out_valid}, 32'h0);
        chk("rst_iready", {28'd0, in_ready}, 32'hF);
        chk("rst_pc1", out_pc1, 32'h0);
        chk("rst_pc4", out_pc4, 32'h0);
        chk("rst_inst1", out_inst1, 32'h0);

        // Fill to 16 entries with no consumption.
        for (int c = 0; c < 4; c++) begin
            set_in(4'b1111, 32'h8000_0000 + 32'(16 * c));
            tick();
            if (c == 0) begin
                chk("fill1_ov", {28'd0, out_valid}, 32'hF);
                chk("fill1_ir", {28'd0, in_ready}, 32'hF);
            end
        end
        chk("full_ir", {28'd0, in_ready}, 32'h0);
        chk("full_ov", {28'd0, out_valid}, 32'hF);
        chk("full_pc1", out_pc1, 32'h8000_0000);
        chk("full_pc2", out_pc2, 32'h8000_0004);
        chk("full_pc3", out_pc3, 32'h8000_0008);
        chk("full_pc4", out_pc4, 32'h8000_000C);
        chk("full_inst1", out_inst1, mk_inst(32'h8000_0000));

        // Drain two at full; new entries land after the wrap.
        out_ready = 4'b0011;
        set_in(4'b1111, 32'h8000_0040);
        tick();
        chk("dr_ir", {28'd0, in_ready}, 32'h3);
        chk("dr_ov", {28'd0, out_valid}, 32'hF);
        chk("dr_pc1", out_pc1, 32'h8000_0008);
        out_ready = 4'b0000;
        tick();
        in_valid = 4'b0000;
        #1;
        chk("wr_ir", {28'd0, in_ready}, 32'h0);
        chk("wr_pc1", out_pc1, 32'h8000_0008);
        out_ready = 4'b1111;
        tick();
        tick();
        tick();
        chk("wr_pc1b", out_pc1, 32'h8000_0038);
        chk("wr_pc3", out_pc3, 32'h8000_0040);
        chk("wr_pc4", out_pc4, 32'h8000_0044);
        chk("wr_inst3", out_inst3, mk_inst(32'h8000_0040));
        tick();
        chk("wr_empty", {28'd0, out_valid}, 32'h0);
        out_ready = 4'b0000;

        // Gap in in_valid accepts only the prefix.
        set_in(4'b0101, 32'h0000_2000);
        #1;
        chk("gap_ir", {28'd0, in_ready}, 32'h3);
        tick();
        chk("gap_ov", {28'd0, out_valid}, 32'h1);
        chk("gap_pc1", out_pc1, 32'h0000_2000);
        clr       = 1'b1;
        out_ready = 4'b1111;
        set_in(4'b1111, 32'h0000_3000);
        tick();
        clr = 1'b0;
        chk("clr_ov", {28'd0, out_valid}, 32'h0);
        chk("clr_ir", {28'd0, in_ready}, 32'hF);
        in_valid = 4'b0000;

        // Stream 40 PCs with random consumption prefixes.
        sent   = 0;
        rcvd   = 0;
        mcount = 0;
        cyc    = 0;
        while (rcvd < 40 && cyc < 400) begin
            nv = (40 - sent) < 4 ? (40 - sent) : 4;
            v  = 4'((1 << nv) - 1);
            set_in(v, 32'h0000_1000 + 32'(4 * sent));
            r         = int'($urandom_range(0, 4));
            out_ready = 4'((1 << r) - 1);
            #1;
            pre = 1'b1;
            for (int i = 0; i < 4; i++) begin
                exp_rdy[i] = ((16 - mcount) > i) && pre;
                pre        = pre & v[i];
                exp_ov[i]  = mcount > i;
            end
            chk("st_ir", {28'd0, in_ready}, {28'd0, exp_rdy});
            chk("st_ov", {28'd0, out_valid}, {28'd0, exp_ov});
            n_acc = 0;
            while (n_acc < 4 && v[n_acc] && exp_rdy[n_acc]) n_acc++;
            n_d = 0;
            while (n_d < 4 && exp_ov[n_d] && out_ready[n_d]) n_d++;
            for (int j = 0; j < n_d; j++) begin
                chk("st_pc", opc[j], 32'h0000_1000 + 32'(4 * rcvd));
                rcvd++;
            end
            sent   += n_acc;
            mcount += n_acc - n_d;
            tick();
            cyc++;
        end
        chk("st_done", 32'(rcvd), 32'd40);
        in_valid  = 4'b0000;
        out_ready = 4'b0000;

`ifdef YSYX_24100029_IBUF_PERF_EN
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("pf_rst", ifu_stall | ibuf_full_cyc, 32'h0);
        for (int c = 0; c < 7; c++) begin
            set_in(4'b1111, 32'h0000_4000 + 32'(16 * c));
            tick();
        end
        chk("pf_stall", ifu_stall, 32'd3);
        chk("pf_full", ibuf_full_cyc, 32'd3);
        // The clr edge itself still sees a full queue.
        in_valid = 4'b0000;
        clr      = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        chk("pf_clr_ov", {28'd0, out_valid}, 32'h0);
        chk("pf_clr_stall", ifu_stall, 32'd3);
        chk("pf_clr_full", ibuf_full_cyc, 32'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
